// File: rtl/portd_shift_out_pkg.sv
// Shared types and constants for the PORTD serial shift-out block.
package portd_shift_out_pkg;

  localparam int unsigned CLK_DIV_MIN = 1;
  localparam int unsigned CLK_DIV_MAX = 255;
  localparam int unsigned PHASE_W     = 8;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned BIT_CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_e;

endpackage

// File: rtl/portd_phase_tick.sv
// Serial-clock phase counter: strobes tick_c on the last cycle of each CLK_DIV-long phase.
module portd_phase_tick
  import portd_shift_out_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick_c
);

  // Out-of-range divisors are clamped into the legal window.
  localparam int unsigned DIV = (CLK_DIV < CLK_DIV_MIN) ? CLK_DIV_MIN :
                                (CLK_DIV > CLK_DIV_MAX) ? CLK_DIV_MAX : CLK_DIV;
  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(DIV - 1);

  logic [PHASE_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PHASE_W'(1);
    end
  end

  assign tick_c = en && !clr && (cnt == LAST);

endmodule

// File: rtl/portd_shift_out.sv
// Mirrors the PORTD PIO byte into an external 74HC595 whenever it changes.
module portd_shift_out
  import portd_shift_out_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [BYTE_W-1:0]   data_in,
  output logic                sr_clk,
  output logic                sr_data,
  output logic                sr_latch,
  output logic                busy
);

  state_e               state, state_nx;
  logic [BYTE_W-1:0]    shreg, shreg_nx;
  logic [BYTE_W-1:0]    shadow, shadow_nx;
  logic                 pending, pending_nx;
  logic [BIT_CNT_W-1:0] bit_cnt, bit_cnt_nx;
  logic                 sr_clk_nx, sr_data_nx, sr_latch_nx, busy_nx;
  logic                 phase_clr_c, phase_en_c, phase_tick_c;

  assign phase_clr_c = (state == IDLE);
  assign phase_en_c  = (state != IDLE);

  portd_phase_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (phase_clr_c),
    .en      (phase_en_c),
    .tick_c  (phase_tick_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      shreg    <= '0;
      shadow   <= '0;
      pending  <= 1'b1;
      bit_cnt  <= '0;
      sr_clk   <= 1'b0;
      sr_data  <= 1'b0;
      sr_latch <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      shadow   <= shadow_nx;
      pending  <= pending_nx;
      bit_cnt  <= bit_cnt_nx;
      sr_clk   <= sr_clk_nx;
      sr_data  <= sr_data_nx;
      sr_latch <= sr_latch_nx;
      busy     <= busy_nx;
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    shadow_nx  = shadow;
    pending_nx = pending;
    bit_cnt_nx = bit_cnt;

    case (state)
      IDLE: begin
        if (pending || (data_in != shadow)) begin
          state_nx   = SHIFT_LO;
          shreg_nx   = data_in;
          shadow_nx  = data_in;
          pending_nx = 1'b0;
          bit_cnt_nx = '0;
        end
      end
      SHIFT_LO: begin
        if (phase_tick_c) state_nx = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (phase_tick_c) begin
          if (bit_cnt == BIT_CNT_W'(7)) begin
            state_nx = LATCH;
          end else begin
            bit_cnt_nx = bit_cnt + BIT_CNT_W'(1);
            shreg_nx   = MSB_FIRST ? {shreg[BYTE_W-2:0], 1'b0} : {1'b0, shreg[BYTE_W-1:1]};
            state_nx   = SHIFT_LO;
          end
        end
      end
      LATCH: begin
        if (phase_tick_c) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    sr_clk_nx   = (state_nx == SHIFT_HI);
    sr_latch_nx = (state_nx == LATCH);
    busy_nx     = (state_nx != IDLE);
    sr_data_nx  = 1'b0;
    if ((state_nx == SHIFT_LO) || (state_nx == SHIFT_HI)) begin
      sr_data_nx = MSB_FIRST ? shreg_nx[BYTE_W-1] : shreg_nx[0];
    end
  end

endmodule

// File: tb/tb_portd_shift_out.sv
// Bench for portd_shift_out: three configurations against a transfer-level model and a 595 model.
module tb_portd_shift_out;

  localparam int NI = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [7:0]    data_in;
  logic [NI-1:0] o_clk, o_data, o_latch, o_busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  portd_shift_out #(.CLK_DIV(4), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .reset_n(reset_n), .data_in(data_in),
    .sr_clk(o_clk[0]), .sr_data(o_data[0]), .sr_latch(o_latch[0]), .busy(o_busy[0]));

  portd_shift_out #(.CLK_DIV(4), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .reset_n(reset_n), .data_in(data_in),
    .sr_clk(o_clk[1]), .sr_data(o_data[1]), .sr_latch(o_latch[1]), .busy(o_busy[1]));

  portd_shift_out #(.CLK_DIV(1), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .reset_n(reset_n), .data_in(data_in),
    .sr_clk(o_clk[2]), .sr_data(o_data[2]), .sr_latch(o_latch[2]), .busy(o_busy[2]));

  int div_of[NI] = '{4, 4, 1};
  bit msb_of[NI] = '{1'b1, 1'b0, 1'b1};

  // Transfer-level model: remaining busy cycles, last byte sent, forced-send flag.
  int         left[NI];
  logic [7:0] shadow_m[NI];
  bit         pend_m[NI];
  logic [7:0] exp_q[NI][$];

  // External 595 model and monitor state.
  logic [7:0] sr595[NI];
  int         rises[NI];
  int         lwidth[NI];
  bit         prev_clk[NI];
  bit         prev_lat[NI];
  logic [7:0] log_q[NI][$];

  typedef struct {
    logic [7:0] data;
    int         cycles;
    int         exp_n;
    logic [7:0] exp_last;
  } vec_t;

  vec_t vecs[7];
  int   base[NI];
  int   bc[NI];

  task automatic check(input string name, input int inst, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst=%0d actual=0x%0h expected=0x%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic set_reset(input logic v);
    reset_n = v;
    if (!v) begin
      for (int i = 0; i < NI; i++) begin
        left[i]     = 0;
        pend_m[i]   = 1'b1;
        shadow_m[i] = 8'h00;
        exp_q[i].delete();
        rises[i]    = 0;
        lwidth[i]   = 0;
        prev_clk[i] = 1'b0;
        prev_lat[i] = 1'b0;
      end
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      if (reset_n) begin
        if (left[i] > 0) begin
          left[i]--;
        end else if (pend_m[i] || (data_in != shadow_m[i])) begin
          pend_m[i]   = 1'b0;
          shadow_m[i] = data_in;
          left[i]     = 17 * div_of[i];
          exp_q[i].push_back(data_in);
        end
      end
    end
  endtask

  task automatic monitor();
    logic [7:0] e;
    for (int i = 0; i < NI; i++) begin
      check("busy", i, int'(o_busy[i]), int'(left[i] > 0));
      if (left[i] == 0)
        check("idle_outputs", i, int'({o_clk[i], o_latch[i], o_data[i]}), 0);
      if (o_clk[i] && !prev_clk[i]) begin
        rises[i]++;
        sr595[i] = msb_of[i] ? {sr595[i][6:0], o_data[i]} : {o_data[i], sr595[i][7:1]};
      end
      if (o_latch[i]) lwidth[i]++;
      if (o_latch[i] && !prev_lat[i]) begin
        check("sr_clk_rises_per_latch", i, rises[i], 8);
        rises[i] = 0;
        log_q[i].push_back(sr595[i]);
        check("latch_was_expected", i, int'(exp_q[i].size() > 0), 1);
        if (exp_q[i].size() > 0) begin
          e = exp_q[i].pop_front();
          check("latched_byte", i, int'(sr595[i]), int'(e));
        end
      end
      if (!o_latch[i] && prev_lat[i]) begin
        check("latch_width", i, lwidth[i], div_of[i]);
        lwidth[i] = 0;
      end
      prev_clk[i] = o_clk[i];
      prev_lat[i] = o_latch[i];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    monitor();
  endtask

  task automatic mark_base();
    for (int i = 0; i < NI; i++) begin
      base[i] = log_q[i].size();
      bc[i]   = 0;
    end
  endtask

  task automatic run_count_busy(input int n);
    repeat (n) begin
      tick();
      for (int i = 0; i < NI; i++) bc[i] += int'(o_busy[i]);
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 80, 1, 8'hA5};
    vecs[1] = '{8'hA5, 200, 0, 8'h00};
    vecs[2] = '{8'h3C, 80, 1, 8'h3C};
    vecs[3] = '{8'h00, 80, 1, 8'h00};
    vecs[4] = '{8'h5A, 80, 1, 8'h5A};
    vecs[5] = '{8'hFF, 80, 1, 8'hFF};
    vecs[6] = '{8'hFF, 100, 0, 8'h00};
    for (int i = 0; i < NI; i++) sr595[i] = 8'h00;

    // Reset state
    data_in = 8'h00;
    set_reset(1'b0);
    repeat (3) tick();
    for (int i = 0; i < NI; i++)
      check("reset_outputs", i, int'({o_busy[i], o_clk[i], o_latch[i], o_data[i]}), 0);

    // Forced transfer of 8'h00 after reset release
    set_reset(1'b1);
    mark_base();
    run_count_busy(80);
    for (int i = 0; i < NI; i++) begin
      check("post_reset_busy_cycles", i, bc[i], 17 * div_of[i]);
      check("post_reset_transfers", i, log_q[i].size() - base[i], 1);
      if (log_q[i].size() > base[i]) check("post_reset_byte", i, int'(log_q[i][base[i]]), 0);
    end

    // Table-driven single-byte updates
    for (int v = 0; v < 7; v++) begin
      mark_base();
      data_in = vecs[v].data;
      repeat (vecs[v].cycles) tick();
      for (int i = 0; i < NI; i++) begin
        check($sformatf("vec%0d_transfers", v), i, log_q[i].size() - base[i], vecs[v].exp_n);
        if (vecs[v].exp_n > 0 && log_q[i].size() > 0)
          check($sformatf("vec%0d_last_byte", v), i, int'(log_q[i][$]), int'(vecs[v].exp_last));
      end
    end

    // Updates while busy: only the last value follows the in-flight byte
    mark_base();
    data_in = 8'h3C; repeat (10) tick();
    data_in = 8'h11; repeat (10) tick();
    data_in = 8'h22; repeat (10) tick();
    data_in = 8'h7E; repeat (160) tick();
    for (int i = 0; i < 2; i++) begin
      check("busy_update_transfers", i, log_q[i].size() - base[i], 2);
      if (log_q[i].size() >= base[i] + 2) begin
        check("busy_update_first", i, int'(log_q[i][base[i]]), 8'h3C);
        check("busy_update_second", i, int'(log_q[i][base[i] + 1]), 8'h7E);
      end
    end

    // Rewriting the same value causes no activity
    mark_base();
    data_in = 8'h7E;
    repeat (200) begin
      tick();
      for (int i = 0; i < NI; i++) bc[i] += int'(o_busy[i] | o_clk[i] | o_latch[i]);
    end
    for (int i = 0; i < NI; i++) check("same_value_activity", i, bc[i], 0);

    // Reset mid-transfer aborts and forces a resend
    mark_base();
    data_in = 8'hFF;
    repeat (30) tick();
    check("busy_before_abort", 0, int'(o_busy[0]), 1);
    set_reset(1'b0);
    #1;
    for (int i = 0; i < NI; i++)
      check("abort_outputs", i, int'({o_busy[i], o_clk[i], o_latch[i], o_data[i]}), 0);
    repeat (2) tick();
    set_reset(1'b1);
    for (int i = 0; i < NI; i++) bc[i] = 0;
    run_count_busy(80);
    for (int i = 0; i < NI; i++) begin
      check("resend_busy_cycles", i, bc[i], 17 * div_of[i]);
      check("resend_transfers", i, log_q[i].size() - base[i], (i == 2) ? 2 : 1);
      if (log_q[i].size() > 0) check("resend_byte", i, int'(log_q[i][$]), 8'hFF);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
